sprite_layer_ctrl: RTL and testbench

SPRITE_LAYER_CTRL -- requirements
Module: sprite_layer_ctrl

---
 rtl/sprite_layer_ctrl.sv | 131 +++++++++++++
 tb/tb_sprite_layer_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_layer_ctrl.sv
// Sprite layer controller: double-buffered sprite list with a frame-synchronised commit
// and a registered lowest-index-wins hit lookup for the current scan pixel.
module sprite_layer_ctrl #(
   parameter int NSLOT = 8,
   parameter int SPR_W = 30,
   parameter int SPR_H = 50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_start,
   input  logic       wr_valid,
   output logic       wr_ready,
   input  logic [2:0] wr_slot,
   input  logic [9:0] wr_x,
   input  logic [9:0] wr_y,
   input  logic [1:0] wr_color,
   input  logic [3:0] wr_glyph,
   input  logic       wr_vis,
   input  logic       commit_req,
   output logic       commit_pending,
   input  logic [9:0] x_cnt,
   input  logic [9:0] y_cnt,
   input  logic       pix_valid,
   output logic       hit,
   output logic [2:0] hit_slot,
   output logic [9:0] x_pin,
   output logic [9:0] y_pin,
   output logic [1:0] color,
   output logic [3:0] glyph
);

   typedef enum logic [1:0] {IDLE, PENDING, COPY} state_t;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic [1:0] color;
      logic [3:0] glyph;
      logic       vis;
   } entry_t;

   localparam logic [2:0] LAST_SLOT = 3'(NSLOT - 1);

   state_t     state, state_next;
   logic [2:0] copy_idx;
   entry_t     shadow [8];
   entry_t     active [8];
   logic       wr_fire;
   logic       slot_in_range;
   logic       any_match;
   logic [2:0] win_idx;
   entry_t     win;

   assign wr_ready       = (state == IDLE) && !rst;
   assign commit_pending = (state != IDLE);
   assign wr_fire        = wr_valid && wr_ready;
   assign slot_in_range  = (32'(wr_slot) < NSLOT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (commit_req)              state_next = PENDING;
         PENDING: if (frame_start)             state_next = COPY;
         COPY:    if (copy_idx == LAST_SLOT)   state_next = IDLE;
         default:                              state_next = IDLE;
      endcase
   end

   // Reset clears both lists so an aborted commit leaves no partial active contents.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
         copy_idx <= '0;
      end else begin
         if (wr_fire && slot_in_range) begin
            shadow[wr_slot] <= {wr_x, wr_y, wr_color, wr_glyph, wr_vis};
         end
         if (state == COPY) begin
            active[copy_idx] <= shadow[copy_idx];
            copy_idx         <= (copy_idx == LAST_SLOT) ? 3'd0 : copy_idx + 3'd1;
         end
      end
   end

   // Scan downwards so the lowest matching index is the last one to claim the win.
   always_comb begin
      any_match = 1'b0;
      win_idx   = '0;
      for (int i = NSLOT - 1; i >= 0; i--) begin
         if (active[i].vis &&
             ({1'b0, active[i].x} <= {1'b0, x_cnt}) &&
             ({1'b0, x_cnt} < ({1'b0, active[i].x} + 11'(SPR_W))) &&
             ({1'b0, active[i].y} <= {1'b0, y_cnt}) &&
             ({1'b0, y_cnt} < ({1'b0, active[i].y} + 11'(SPR_H)))) begin
            any_match = 1'b1;
            win_idx   = 3'(i);
         end
      end
      win = active[win_idx];
   end

   always_ff @(posedge clk) begin
      if (rst || !(pix_valid && any_match && (state != COPY))) begin
         hit      <= 1'b0;
         hit_slot <= '0;
         x_pin    <= '0;
         y_pin    <= '0;
         color    <= '0;
         glyph    <= '0;
      end else begin
         hit      <= 1'b1;
         hit_slot <= win_idx;
         x_pin    <= win.x;
         y_pin    <= win.y;
         color    <= win.color;
         glyph    <= win.glyph;
      end
   end

endmodule

// File: tb/tb_sprite_layer_ctrl.sv
// Testbench for sprite_layer_ctrl: an 8-slot instance for the main behaviour and a
// 4-slot instance for out-of-range slot writes; outputs checked through a scoreboard queue.
module tb_sprite_layer_ctrl;

   typedef struct packed {
      logic       hit;
      logic [2:0] slot;
      logic [9:0] x;
      logic [9:0] y;
      logic [1:0] color;
      logic [3:0] glyph;
   } out_t;

   typedef struct {
      logic [9:0] xc;
      logic [9:0] yc;
      logic       pv;
      out_t       exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst, frame_start;
   logic [9:0] x_cnt, y_cnt;
   logic       pix_valid;

   logic       a_wr_valid, a_wr_ready, a_wr_vis, a_commit_req, a_commit_pending;
   logic [2:0] a_wr_slot;
   logic [9:0] a_wr_x, a_wr_y;
   logic [1:0] a_wr_color;
   logic [3:0] a_wr_glyph;
   logic       a_hit;
   logic [2:0] a_hit_slot;
   logic [9:0] a_x_pin, a_y_pin;
   logic [1:0] a_color;
   logic [3:0] a_glyph;

   logic       b_wr_valid, b_wr_ready, b_wr_vis, b_commit_req, b_commit_pending;
   logic [2:0] b_wr_slot;
   logic [9:0] b_wr_x, b_wr_y;
   logic [1:0] b_wr_color;
   logic [3:0] b_wr_glyph;
   logic       b_hit;
   logic [2:0] b_hit_slot;
   logic [9:0] b_x_pin, b_y_pin;
   logic [1:0] b_color;
   logic [3:0] b_glyph;

   int   tests_run = 0;
   int   tests_failed = 0;
   out_t a_queue[$];
   out_t b_queue[$];
   vec_t vecs[14];

   always #5 clk = ~clk;

   sprite_layer_ctrl #(.NSLOT(8), .SPR_W(30), .SPR_H(50)) dut_a (
      .clk(clk), .rst(rst), .frame_start(frame_start),
      .wr_valid(a_wr_valid), .wr_ready(a_wr_ready), .wr_slot(a_wr_slot),
      .wr_x(a_wr_x), .wr_y(a_wr_y), .wr_color(a_wr_color), .wr_glyph(a_wr_glyph),
      .wr_vis(a_wr_vis), .commit_req(a_commit_req), .commit_pending(a_commit_pending),
      .x_cnt(x_cnt), .y_cnt(y_cnt), .pix_valid(pix_valid),
      .hit(a_hit), .hit_slot(a_hit_slot), .x_pin(a_x_pin), .y_pin(a_y_pin),
      .color(a_color), .glyph(a_glyph)
   );

   sprite_layer_ctrl #(.NSLOT(4), .SPR_W(30), .SPR_H(50)) dut_b (
      .clk(clk), .rst(rst), .frame_start(frame_start),
      .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_slot(b_wr_slot),
      .wr_x(b_wr_x), .wr_y(b_wr_y), .wr_color(b_wr_color), .wr_glyph(b_wr_glyph),
      .wr_vis(b_wr_vis), .commit_req(b_commit_req), .commit_pending(b_commit_pending),
      .x_cnt(x_cnt), .y_cnt(y_cnt), .pix_valid(pix_valid),
      .hit(b_hit), .hit_slot(b_hit_slot), .x_pin(b_x_pin), .y_pin(b_y_pin),
      .color(b_color), .glyph(b_glyph)
   );

   function automatic out_t mk(input logic h, input logic [2:0] s, input logic [9:0] x,
                               input logic [9:0] y, input logic [1:0] c, input logic [3:0] g);
      out_t o;
      o.hit = h; o.slot = s; o.x = x; o.y = y; o.color = c; o.glyph = g;
      return o;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_value(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic check_output(input bit sel, input string name);
      out_t got, exp;
      tests_run++;
      if (sel ? (b_queue.size() == 0) : (a_queue.size() == 0)) begin
         tests_failed++;
         $display("[TB] FAIL %s: scoreboard empty, no expected value", name);
         return;
      end
      exp = sel ? b_queue.pop_front() : a_queue.pop_front();
      got = sel ? mk(b_hit, b_hit_slot, b_x_pin, b_y_pin, b_color, b_glyph)
                : mk(a_hit, a_hit_slot, a_x_pin, a_y_pin, a_color, a_glyph);
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got hit=%0d slot=%0d x=%0d y=%0d color=%0d glyph=%0d, expected hit=%0d slot=%0d x=%0d y=%0d color=%0d glyph=%0d",
                  name, got.hit, got.slot, got.x, got.y, got.color, got.glyph,
                  exp.hit, exp.slot, exp.x, exp.y, exp.color, exp.glyph);
      end
   endtask

   task automatic apply_stimulus(input bit sel, input logic [9:0] xc, input logic [9:0] yc,
                                 input logic pv, input out_t exp, input string name);
      x_cnt = xc; y_cnt = yc; pix_valid = pv;
      if (sel) b_queue.push_back(exp);
      else     a_queue.push_back(exp);
      step();
      check_output(sel, name);
   endtask

   task automatic run_table(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         apply_stimulus(1'b0, vecs[i].xc, vecs[i].yc, vecs[i].pv, vecs[i].exp, $sformatf("vec%0d", i));
      end
   endtask

   task automatic do_write(input bit sel, input logic [2:0] s, input logic [9:0] x, input logic [9:0] y,
                           input logic [1:0] c, input logic [3:0] g, input logic v);
      if (sel) begin
         b_wr_slot = s; b_wr_x = x; b_wr_y = y; b_wr_color = c; b_wr_glyph = g; b_wr_vis = v;
         b_wr_valid = 1'b1;
      end else begin
         a_wr_slot = s; a_wr_x = x; a_wr_y = y; a_wr_color = c; a_wr_glyph = g; a_wr_vis = v;
         a_wr_valid = 1'b1;
      end
      #1;
      check_value($sformatf("wr_ready_write_slot%0d", s), 32'(sel ? b_wr_ready : a_wr_ready), 32'd1);
      step();
      a_wr_valid = 1'b0;
      b_wr_valid = 1'b0;
   endtask

   task automatic do_commit(input bit sel, input int n);
      pix_valid = 1'b0;
      if (sel) b_commit_req = 1'b1;
      else     a_commit_req = 1'b1;
      step();
      a_commit_req = 1'b0;
      b_commit_req = 1'b0;
      check_value("commit_pending_set", 32'(sel ? b_commit_pending : a_commit_pending), 32'd1);
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      repeat (n) step();
      check_value("commit_pending_done", 32'(sel ? b_commit_pending : a_commit_pending), 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vecs[0]  = '{10'd100,  10'd200,  1'b1, mk(1, 2, 100, 200, 1, 3)};
      vecs[1]  = '{10'd130,  10'd200,  1'b1, mk(0, 0, 0, 0, 0, 0)};
      vecs[2]  = '{10'd129,  10'd249,  1'b1, mk(1, 2, 100, 200, 1, 3)};
      vecs[3]  = '{10'd129,  10'd250,  1'b1, mk(0, 0, 0, 0, 0, 0)};
      vecs[4]  = '{10'd99,   10'd200,  1'b1, mk(0, 0, 0, 0, 0, 0)};
      vecs[5]  = '{10'd100,  10'd200,  1'b0, mk(0, 0, 0, 0, 0, 0)};
      vecs[6]  = '{10'd50,   10'd50,   1'b1, mk(1, 1, 40, 40, 2, 5)};
      vecs[7]  = '{10'd35,   10'd35,   1'b1, mk(1, 4, 30, 30, 3, 7)};
      vecs[8]  = '{10'd69,   10'd69,   1'b1, mk(1, 1, 40, 40, 2, 5)};
      vecs[9]  = '{10'd50,   10'd50,   1'b1, mk(1, 4, 30, 30, 3, 7)};
      vecs[10] = '{10'd69,   10'd69,   1'b1, mk(0, 0, 0, 0, 0, 0)};
      vecs[11] = '{10'd5,    10'd5,    1'b1, mk(0, 0, 0, 0, 0, 0)};
      vecs[12] = '{10'd1023, 10'd1023, 1'b1, mk(1, 3, 1000, 1000, 0, 1)};
      vecs[13] = '{10'd1000, 10'd999,  1'b1, mk(0, 0, 0, 0, 0, 0)};

      rst = 1'b1; frame_start = 1'b0; x_cnt = '0; y_cnt = '0; pix_valid = 1'b0;
      a_wr_valid = 1'b0; a_wr_slot = '0; a_wr_x = '0; a_wr_y = '0; a_wr_color = '0;
      a_wr_glyph = '0; a_wr_vis = 1'b0; a_commit_req = 1'b0;
      b_wr_valid = 1'b0; b_wr_slot = '0; b_wr_x = '0; b_wr_y = '0; b_wr_color = '0;
      b_wr_glyph = '0; b_wr_vis = 1'b0; b_commit_req = 1'b0;

      step();
      apply_stimulus(1'b0, 10'd0, 10'd0, 1'b1, mk(0, 0, 0, 0, 0, 0), "reset_outputs");
      check_value("reset_commit_pending", 32'(a_commit_pending), 32'd0);
      check_value("reset_wr_ready_low", 32'(a_wr_ready), 32'd0);
      rst = 1'b0;
      #1;
      check_value("release_wr_ready", 32'(a_wr_ready), 32'd1);

      // Basic box, edge-exclusive bounds and pix_valid gating
      do_write(1'b0, 3'd2, 10'd100, 10'd200, 2'd1, 4'd3, 1'b1);
      do_commit(1'b0, 8);
      run_table(0, 5);

      // Overlap priority, then hiding the winner
      do_write(1'b0, 3'd1, 10'd40, 10'd40, 2'd2, 4'd5, 1'b1);
      do_write(1'b0, 3'd4, 10'd30, 10'd30, 2'd3, 4'd7, 1'b1);
      do_commit(1'b0, 8);
      run_table(6, 8);
      do_write(1'b0, 3'd1, 10'd40, 10'd40, 2'd2, 4'd5, 1'b0);
      do_commit(1'b0, 8);
      run_table(9, 10);

      // Uncommitted shadow write, coincident commit/frame_start, COPY window
      do_write(1'b0, 3'd0, 10'd300, 10'd300, 2'd1, 4'd9, 1'b1);
      apply_stimulus(1'b0, 10'd310, 10'd310, 1'b1, mk(0, 0, 0, 0, 0, 0), "shadow_not_visible");
      a_commit_req = 1'b1; frame_start = 1'b1;
      step();
      a_commit_req = 1'b0; frame_start = 1'b0;
      check_value("coincident_commit_pending", 32'(a_commit_pending), 32'd1);
      check_value("coincident_wr_ready", 32'(a_wr_ready), 32'd0);
      apply_stimulus(1'b0, 10'd35, 10'd35, 1'b1, mk(1, 4, 30, 30, 3, 7), "pending_hit_0");
      apply_stimulus(1'b0, 10'd35, 10'd35, 1'b1, mk(1, 4, 30, 30, 3, 7), "pending_hit_1");
      frame_start = 1'b1;
      apply_stimulus(1'b0, 10'd35, 10'd35, 1'b1, mk(1, 4, 30, 30, 3, 7), "frame_start_edge");
      frame_start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check_value($sformatf("copy%0d_wr_ready", i), 32'(a_wr_ready), 32'd0);
         check_value($sformatf("copy%0d_pending", i), 32'(a_commit_pending), 32'd1);
         apply_stimulus(1'b0, 10'd35, 10'd35, 1'b1, mk(0, 0, 0, 0, 0, 0), $sformatf("copy%0d_hit", i));
      end
      check_value("after_copy_pending", 32'(a_commit_pending), 32'd0);
      check_value("after_copy_wr_ready", 32'(a_wr_ready), 32'd1);
      apply_stimulus(1'b0, 10'd35, 10'd35, 1'b1, mk(1, 4, 30, 30, 3, 7), "after_copy_slot4");
      apply_stimulus(1'b0, 10'd310, 10'd310, 1'b1, mk(1, 0, 300, 300, 1, 9), "after_copy_slot0");

      // No wrap at the right/bottom edge of the coordinate space
      do_write(1'b0, 3'd3, 10'd1000, 10'd1000, 2'd0, 4'd1, 1'b1);
      do_commit(1'b0, 8);
      run_table(11, 13);

      // Reset in the middle of a copy aborts it and clears everything
      a_commit_req = 1'b1;
      step();
      a_commit_req = 1'b0;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      repeat (3) step();
      rst = 1'b1;
      apply_stimulus(1'b0, 10'd35, 10'd35, 1'b1, mk(0, 0, 0, 0, 0, 0), "abort_outputs");
      check_value("abort_pending", 32'(a_commit_pending), 32'd0);
      check_value("abort_wr_ready_in_reset", 32'(a_wr_ready), 32'd0);
      rst = 1'b0;
      #1;
      check_value("abort_wr_ready_release", 32'(a_wr_ready), 32'd1);
      apply_stimulus(1'b0, 10'd35, 10'd35, 1'b1, mk(0, 0, 0, 0, 0, 0), "abort_slot4_gone");
      apply_stimulus(1'b0, 10'd1023, 10'd1023, 1'b1, mk(0, 0, 0, 0, 0, 0), "abort_slot3_gone");
      do_commit(1'b0, 8);
      apply_stimulus(1'b0, 10'd35, 10'd35, 1'b1, mk(0, 0, 0, 0, 0, 0), "abort_shadow_cleared");

      // Out-of-range slot on the 4-slot instance
      do_write(1'b1, 3'd1, 10'd60, 10'd60, 2'd2, 4'd2, 1'b1);
      do_commit(1'b1, 4);
      apply_stimulus(1'b1, 10'd60, 10'd60, 1'b1, mk(1, 1, 60, 60, 2, 2), "b_slot1");
      do_write(1'b1, 3'd7, 10'd200, 10'd200, 2'd3, 4'd15, 1'b1);
      do_commit(1'b1, 4);
      apply_stimulus(1'b1, 10'd200, 10'd200, 1'b1, mk(0, 0, 0, 0, 0, 0), "b_slot7_ignored");
      apply_stimulus(1'b1, 10'd60, 10'd60, 1'b1, mk(1, 1, 60, 60, 2, 2), "b_slot1_kept");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
